hyper_lsab_cr: RTL and testbench

Four-section receive buffer (LSAB, "cr" side) that sits directly upstream of the DRAM block mover. Hyperfabric receive logic writes tagged words into one of four independent FIFO sections. The block mover drains a chosen section and sees per-section STOP, INT and ANCILL status. Block boundaries are carried as an end tag on the last word, and STOP holds the section closed at a boundary until the driver releases it.

---
 rtl/hyper_lsab_pkg.sv | 32 +++
 rtl/hyper_lsab_ram.sv | 56 +++++
 rtl/hyper_lsab_cr.sv | 201 ++++++++++++++++++++
 tb/tb_hyper_lsab_cr.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyper_lsab_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hyper_lsab_pkg                                               |
// | Description : Shared constants for the four-section LSAB receive buffer:   |
// |               section count, ancillary tag width and the bit layout of a   |
// |               stored entry {END, ANCILL[2:0], DATA}.                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package hyper_lsab_pkg;

  localparam int LSAB_SECTIONS = 4;
  localparam int SEC_W         = 2;
  localparam int ANCILL_W      = 3;

  // DATA occupies the low bits of an entry, ANCILL sits directly above it,
  // END is the top bit.
  localparam int ENT_DATA_LSB  = 0;

  function automatic int ent_ancill_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int ent_end_bit(input int data_w);
    return data_w + ANCILL_W;
  endfunction

  function automatic int ent_width(input int data_w);
    return data_w + ANCILL_W + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hyper_lsab_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hyper_lsab_ram                                               |
// | Description : Simple dual-port entry store shared by all four sections.    |
// |               One write port, one read port with a registered output that  |
// |               holds its value when no read is requested.                   |
// | Ports       : clk, rst        clock / sync active-high reset (output reg)  |
// |               wr_en/addr/data write port                                   |
// |               rd_en/addr      read request                                 |
// |               rd_data         registered read data                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hyper_lsab_ram #(
  parameter int ADDR_W = 7,
  parameter int ENT_W  = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ENT_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ENT_W-1:0]  rd_data
);

  logic [ENT_W-1:0] mem_q [2**ADDR_W];
  logic [ENT_W-1:0] rd_data_q;
  logic [ENT_W-1:0] rd_data_d;

  // Storage itself is not reset; only the output register is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/hyper_lsab_cr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hyper_lsab_cr                                                |
// | Description : Four-section receive buffer feeding the DRAM block mover.    |
// |               Tagged words are written into one of four FIFO sections; the |
// |               reader drains a section and sees per-section STOP/INT/ANCILL.|
// |               A word carrying END closes its section (boundary) until      |
// |               BOUNDARY_CLR releases it.                                    |
// | Config      : `define HYPER_LSAB_OVERFLOW_EN builds sticky OVERFLOW flags; |
// |               otherwise OVERFLOW is tied low.                              |
// | Ports       : CLK, RST                  clock / sync active-high reset     |
// |               WRITE*                    write side, FULL, OVERFLOW         |
// |               LSAB_READ/SECTION/DATA    read side                          |
// |               LSAB_n_STOP/INT/ANCILL    per-section status                 |
// |               BOUNDARY_CLR/SECTION      boundary release                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hyper_lsab_cr
  import hyper_lsab_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5,
  parameter int DATA_W     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WRITE,
  input  logic [1:0]        WRITE_SECTION,
  input  logic [DATA_W-1:0] WRITE_DATA,
  input  logic              WRITE_END,
  input  logic [2:0]        WRITE_ANCILL,
  output logic [3:0]        FULL,
  output logic [3:0]        OVERFLOW,
  input  logic              LSAB_READ,
  input  logic [1:0]        LSAB_SECTION,
  output logic [DATA_W-1:0] LSAB_DATA,
  output logic              LSAB_0_STOP,
  output logic              LSAB_1_STOP,
  output logic              LSAB_2_STOP,
  output logic              LSAB_3_STOP,
  output logic              LSAB_0_INT,
  output logic              LSAB_1_INT,
  output logic              LSAB_2_INT,
  output logic              LSAB_3_INT,
  output logic [2:0]        LSAB_0_ANCILL,
  output logic [2:0]        LSAB_1_ANCILL,
  output logic [2:0]        LSAB_2_ANCILL,
  output logic [2:0]        LSAB_3_ANCILL,
  input  logic              BOUNDARY_CLR,
  input  logic [1:0]        BOUNDARY_SECTION
);

  localparam int PTR_W   = DEPTH_LOG2 + 1;
  localparam int ADDR_W  = SEC_W + DEPTH_LOG2;
  localparam int ENT_W   = ent_width(DATA_W);
  localparam int ANC_LSB = ent_ancill_lsb(DATA_W);
  localparam int END_BIT = ent_end_bit(DATA_W);

  logic [LSAB_SECTIONS-1:0][PTR_W-1:0]    wp_q, wp_d;
  logic [LSAB_SECTIONS-1:0][PTR_W-1:0]    rp_q, rp_d;
  logic [LSAB_SECTIONS-1:0]               boundary_q, boundary_d;
  logic [LSAB_SECTIONS-1:0]               int_q, int_d;
  logic [LSAB_SECTIONS-1:0][ANCILL_W-1:0] ancill_q, ancill_d;
  logic                                   rd_vld_q, rd_vld_d;
  logic [SEC_W-1:0]                       rd_sec_q, rd_sec_d;

  logic [LSAB_SECTIONS-1:0]               empty;
  logic [LSAB_SECTIONS-1:0]               full;
  logic [LSAB_SECTIONS-1:0]               boundary_eff;
  logic [LSAB_SECTIONS-1:0]               int_eff;
  logic [LSAB_SECTIONS-1:0][ANCILL_W-1:0] ancill_eff;
  logic [LSAB_SECTIONS-1:0]               stop;

  logic [ENT_W-1:0]                       rd_entry;
  logic                                   rd_end;
  logic [ANCILL_W-1:0]                    rd_ancill;
  logic                                   wr_acc;
  logic                                   rd_acc;

  assign rd_end    = rd_entry[END_BIT];
  assign rd_ancill = rd_entry[ANC_LSB +: ANCILL_W];

  // The entry read at edge k only emerges from the RAM register after that
  // edge, so the tag of the most recent read is folded in combinationally
  // here and absorbed into the per-section registers at the following edge.
  // The result behaves as if INT/ANCILL/boundary were loaded at edge k.
  for (genvar n = 0; n < LSAB_SECTIONS; n++) begin : g_status
    logic landing;
    assign landing         = rd_vld_q && (rd_sec_q == SEC_W'(n));
    assign empty[n]        = (wp_q[n] == rp_q[n]);
    assign full[n]         = (wp_q[n][PTR_W-1] != rp_q[n][PTR_W-1]) &&
                             (wp_q[n][DEPTH_LOG2-1:0] == rp_q[n][DEPTH_LOG2-1:0]);
    assign boundary_eff[n] = boundary_q[n] | (landing & rd_end);
    assign int_eff[n]      = landing ? rd_end    : int_q[n];
    assign ancill_eff[n]   = landing ? rd_ancill : ancill_q[n];
    assign stop[n]         = empty[n] | boundary_eff[n];
  end

  // FULL and STOP are judged on pre-edge state, so a same-cycle read never
  // makes room for a write to a full section, and an empty section cannot be
  // read in the cycle it is written.
  assign wr_acc = WRITE && !full[WRITE_SECTION];
  assign rd_acc = LSAB_READ && !stop[LSAB_SECTION];

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    boundary_d = boundary_eff;
    int_d      = int_eff;
    ancill_d   = ancill_eff;
    rd_vld_d   = rd_acc;
    rd_sec_d   = rd_sec_q;

    if (wr_acc) begin
      wp_d[WRITE_SECTION] = wp_q[WRITE_SECTION] + PTR_W'(1);
    end
    if (rd_acc) begin
      rp_d[LSAB_SECTION] = rp_q[LSAB_SECTION] + PTR_W'(1);
      rd_sec_d           = LSAB_SECTION;
    end
    // A simultaneous END read on the released section lands one edge later
    // through boundary_eff, so the set takes precedence over this clear.
    if (BOUNDARY_CLR) begin
      boundary_d[BOUNDARY_SECTION] = 1'b0;
      int_d[BOUNDARY_SECTION]      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wp_q       <= '0;
      rp_q       <= '0;
      boundary_q <= '0;
      int_q      <= '0;
      ancill_q   <= '0;
      rd_vld_q   <= 1'b0;
      rd_sec_q   <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      boundary_q <= boundary_d;
      int_q      <= int_d;
      ancill_q   <= ancill_d;
      rd_vld_q   <= rd_vld_d;
      rd_sec_q   <= rd_sec_d;
    end
  end

  hyper_lsab_ram #(
    .ADDR_W (ADDR_W),
    .ENT_W  (ENT_W)
  ) u_ram (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (wr_acc),
    .wr_addr ({WRITE_SECTION, wp_q[WRITE_SECTION][DEPTH_LOG2-1:0]}),
    .wr_data ({WRITE_END, WRITE_ANCILL, WRITE_DATA}),
    .rd_en   (rd_acc),
    .rd_addr ({LSAB_SECTION, rp_q[LSAB_SECTION][DEPTH_LOG2-1:0]}),
    .rd_data (rd_entry)
  );

`ifdef HYPER_LSAB_OVERFLOW_EN
  logic [LSAB_SECTIONS-1:0] overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (WRITE && full[WRITE_SECTION]) begin
      overflow_d[WRITE_SECTION] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow_q <= '0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign OVERFLOW = overflow_q;
`else
  assign OVERFLOW = 4'b0000;
`endif

  assign FULL          = full;
  assign LSAB_DATA     = rd_entry[ENT_DATA_LSB +: DATA_W];
  assign LSAB_0_STOP   = stop[0];
  assign LSAB_1_STOP   = stop[1];
  assign LSAB_2_STOP   = stop[2];
  assign LSAB_3_STOP   = stop[3];
  assign LSAB_0_INT    = int_eff[0];
  assign LSAB_1_INT    = int_eff[1];
  assign LSAB_2_INT    = int_eff[2];
  assign LSAB_3_INT    = int_eff[3];
  assign LSAB_0_ANCILL = ancill_eff[0];
  assign LSAB_1_ANCILL = ancill_eff[1];
  assign LSAB_2_ANCILL = ancill_eff[2];
  assign LSAB_3_ANCILL = ancill_eff[3];

endmodule
`default_nettype wire

// File: tb/tb_hyper_lsab_cr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hyper_lsab_cr                                             |
// | Description : Self-checking bench for hyper_lsab_cr. A queue-based model   |
// |               of the four sections tracks STOP/FULL/INT/ANCILL/OVERFLOW;   |
// |               expected read data is pushed to a scoreboard when a read is  |
// |               driven and popped when LSAB_DATA is due.                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_hyper_lsab_cr;

  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic [1:0]  write_section;
  logic [31:0] write_data;
  logic        write_end;
  logic [2:0]  write_ancill;
  logic [3:0]  full;
  logic [3:0]  overflow;
  logic        lsab_read;
  logic [1:0]  lsab_section;
  logic [31:0] lsab_data;
  logic        stop0, stop1, stop2, stop3;
  logic        int0, int1, int2, int3;
  logic [2:0]  anc0, anc1, anc2, anc3;
  logic        boundary_clr;
  logic [1:0]  boundary_section;

  always #5 clk = ~clk;

  hyper_lsab_cr #(.DEPTH_LOG2(5), .DATA_W(32)) dut (
    .CLK(clk), .RST(rst),
    .WRITE(write), .WRITE_SECTION(write_section), .WRITE_DATA(write_data),
    .WRITE_END(write_end), .WRITE_ANCILL(write_ancill),
    .FULL(full), .OVERFLOW(overflow),
    .LSAB_READ(lsab_read), .LSAB_SECTION(lsab_section), .LSAB_DATA(lsab_data),
    .LSAB_0_STOP(stop0), .LSAB_1_STOP(stop1), .LSAB_2_STOP(stop2), .LSAB_3_STOP(stop3),
    .LSAB_0_INT(int0), .LSAB_1_INT(int1), .LSAB_2_INT(int2), .LSAB_3_INT(int3),
    .LSAB_0_ANCILL(anc0), .LSAB_1_ANCILL(anc1), .LSAB_2_ANCILL(anc2), .LSAB_3_ANCILL(anc3),
    .BOUNDARY_CLR(boundary_clr), .BOUNDARY_SECTION(boundary_section)
  );

  // ---------------- model state ----------------
  logic [35:0] mq [4][$];
  logic [31:0] sb_q [$];
  logic [3:0]  m_bnd;
  logic [3:0]  m_int;
  logic [2:0]  m_anc [4];
  logic [3:0]  m_ovf;
  logic [31:0] m_data;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] model_stop();
    logic [3:0] s;
    for (int n = 0; n < 4; n++) s[n] = (mq[n].size() == 0) || m_bnd[n];
    return s;
  endfunction

  function automatic logic [3:0] model_full();
    logic [3:0] f;
    for (int n = 0; n < 4; n++) f[n] = (mq[n].size() == 32);
    return f;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      mq[n].delete();
      m_anc[n] = 3'd0;
    end
    sb_q.delete();
    m_bnd  = 4'd0;
    m_int  = 4'd0;
    m_ovf  = 4'd0;
    m_data = 32'd0;
  endtask

  task automatic check_all();
    logic [3:0] ovf_exp;
`ifdef HYPER_LSAB_OVERFLOW_EN
    ovf_exp = m_ovf;
`else
    ovf_exp = 4'd0;
`endif
    chk("stop",     {60'd0, stop3, stop2, stop1, stop0}, {60'd0, model_stop()});
    chk("full",     {60'd0, full},                       {60'd0, model_full()});
    chk("int",      {60'd0, int3, int2, int1, int0},     {60'd0, m_int});
    chk("ancill",   {52'd0, anc3, anc2, anc1, anc0},
                    {52'd0, m_anc[3], m_anc[2], m_anc[1], m_anc[0]});
    chk("overflow", {60'd0, overflow},                   {60'd0, ovf_exp});
    chk("data",     {32'd0, lsab_data},                  {32'd0, m_data});
  endtask

  // One clock: drive, decide acceptance from pre-edge model state, clock,
  // update the model and compare every output.
  task automatic step(input logic wr, input logic [1:0] ws, input logic [31:0] wd,
                      input logic we, input logic [2:0] wa,
                      input logic rd, input logic [1:0] rs,
                      input logic clr, input logic [1:0] cs, input logic rs_in);
    logic [3:0]  pre_stop, pre_full;
    logic        wr_ok, rd_ok;
    logic [35:0] e;
    rst = rs_in; write = wr; write_section = ws; write_data = wd;
    write_end = we; write_ancill = wa; lsab_read = rd; lsab_section = rs;
    boundary_clr = clr; boundary_section = cs;
    pre_stop = model_stop();
    pre_full = model_full();
    wr_ok = wr && !pre_full[ws];
    rd_ok = rd && !pre_stop[rs];
    e = '0;
    if (rd_ok && !rs_in) begin
      e = mq[rs][0];
      sb_q.push_back(e[31:0]);
    end
    @(posedge clk);
    #1;
    if (rs_in) begin
      model_reset();
    end else begin
      if (wr && pre_full[ws]) m_ovf[ws] = 1'b1;
      if (clr) begin
        m_bnd[cs] = 1'b0;
        m_int[cs] = 1'b0;
      end
      if (rd_ok) begin
        void'(mq[rs].pop_front());
        m_int[rs] = e[35];
        m_anc[rs] = e[34:32];
        if (e[35]) m_bnd[rs] = 1'b1;
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
          m_data = sb_q.pop_front();
        end
      end
      if (wr_ok) mq[ws].push_back({we, wa, wd});
    end
    check_all();
  endtask

  task automatic idle(input logic rs_in);
    step(1'b0, 2'd0, 32'd0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 2'd0, rs_in);
  endtask

  task automatic wr_only(input logic [1:0] ws, input logic [31:0] wd,
                         input logic we, input logic [2:0] wa);
    step(1'b1, ws, wd, we, wa, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic rd_only(input logic [1:0] rs);
    step(1'b0, 2'd0, 32'd0, 1'b0, 3'd0, 1'b1, rs, 1'b0, 2'd0, 1'b0);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  ws;
    logic [31:0] wd;
    logic        we;
    logic [2:0]  wa;
    logic        rd;
    logic [1:0]  rs;
    logic        clr;
    logic [1:0]  cs;
    logic [3:0]  exp_stop;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // Section 1 block sequence, boundary hold/release, set-beats-clear.
    tbl[0]  = '{1'b0, 2'd0, 32'h0,         1'b0, 3'd0, 1'b1, 2'd2, 1'b0, 2'd0, 4'b1111, 32'h0};
    tbl[1]  = '{1'b1, 2'd1, 32'h1111_0001, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b1101, 32'h0};
    tbl[2]  = '{1'b1, 2'd1, 32'h1111_0002, 1'b0, 3'd1, 1'b0, 2'd0, 1'b0, 2'd0, 4'b1101, 32'h0};
    tbl[3]  = '{1'b1, 2'd1, 32'h1111_0003, 1'b1, 3'd5, 1'b0, 2'd0, 1'b0, 2'd0, 4'b1101, 32'h0};
    tbl[4]  = '{1'b0, 2'd0, 32'h0,         1'b0, 3'd0, 1'b1, 2'd1, 1'b0, 2'd0, 4'b1101, 32'h1111_0001};
    tbl[5]  = '{1'b0, 2'd0, 32'h0,         1'b0, 3'd0, 1'b1, 2'd1, 1'b0, 2'd0, 4'b1101, 32'h1111_0002};
    tbl[6]  = '{1'b0, 2'd0, 32'h0,         1'b0, 3'd0, 1'b1, 2'd1, 1'b0, 2'd0, 4'b1111, 32'h1111_0003};
    tbl[7]  = '{1'b0, 2'd0, 32'h0,         1'b0, 3'd0, 1'b1, 2'd1, 1'b0, 2'd0, 4'b1111, 32'h1111_0003};
    tbl[8]  = '{1'b1, 2'd1, 32'h2222_0001, 1'b0, 3'd2, 1'b0, 2'd0, 1'b0, 2'd0, 4'b1111, 32'h1111_0003};
    tbl[9]  = '{1'b1, 2'd1, 32'h2222_0002, 1'b0, 3'd3, 1'b0, 2'd0, 1'b0, 2'd0, 4'b1111, 32'h1111_0003};
    tbl[10] = '{1'b0, 2'd0, 32'h0,         1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 2'd1, 4'b1101, 32'h1111_0003};
    tbl[11] = '{1'b0, 2'd0, 32'h0,         1'b0, 3'd0, 1'b1, 2'd1, 1'b0, 2'd0, 4'b1101, 32'h2222_0001};
    tbl[12] = '{1'b0, 2'd0, 32'h0,         1'b0, 3'd0, 1'b1, 2'd1, 1'b0, 2'd0, 4'b1111, 32'h2222_0002};
    tbl[13] = '{1'b1, 2'd1, 32'h3333_0001, 1'b1, 3'd2, 1'b0, 2'd0, 1'b0, 2'd0, 4'b1101, 32'h2222_0002};
    tbl[14] = '{1'b1, 2'd1, 32'h3333_0002, 1'b0, 3'd6, 1'b0, 2'd0, 1'b0, 2'd0, 4'b1101, 32'h2222_0002};
    tbl[15] = '{1'b0, 2'd0, 32'h0,         1'b0, 3'd0, 1'b1, 2'd1, 1'b1, 2'd1, 4'b1111, 32'h3333_0001};
    tbl[16] = '{1'b0, 2'd0, 32'h0,         1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 2'd1, 4'b1101, 32'h3333_0001};
    tbl[17] = '{1'b0, 2'd0, 32'h0,         1'b0, 3'd0, 1'b1, 2'd1, 1'b0, 2'd0, 4'b1111, 32'h3333_0002};

    model_reset();
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].wr, tbl[i].ws, tbl[i].wd, tbl[i].we, tbl[i].wa,
           tbl[i].rd, tbl[i].rs, tbl[i].clr, tbl[i].cs, 1'b0);
      chk($sformatf("tbl%0d_stop", i), {60'd0, stop3, stop2, stop1, stop0},
          {60'd0, tbl[i].exp_stop});
      chk($sformatf("tbl%0d_data", i), {32'd0, lsab_data}, {32'd0, tbl[i].exp_data});
      if (i == 6) begin
        chk("int1_after_end",    {63'd0, int1}, 64'd1);
        chk("ancill1_after_end", {61'd0, anc1}, 64'd5);
      end
      if (i == 10) chk("int1_after_clr", {63'd0, int1}, 64'd0);
    end

    // Fill section 0 to capacity, then one extra write that must be dropped.
    for (int i = 0; i < 32; i++) begin
      wr_only(2'd0, 32'hF000_0000 + i, 1'b0, 3'(i));
      chk("full0_during_fill", {63'd0, full[0]}, {63'd0, (i == 31)});
    end
    wr_only(2'd0, 32'hDEAD_BEEF, 1'b0, 3'd7);
    chk("full0_after_extra", {63'd0, full[0]}, 64'd1);
`ifdef HYPER_LSAB_OVERFLOW_EN
    chk("overflow0", {63'd0, overflow[0]}, 64'd1);
`endif

    // Write section 3 / read section 0 every cycle: drains section 0,
    // fills and overflows section 3.
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 2'd3, 32'h3000_0000 + i, i[2], 3'(i), 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
      if (i == 31) chk("data_last_of_fill", {32'd0, lsab_data}, 64'hF000_001F);
    end
    // Read and write section 3 together so its pointers wrap; release any
    // boundary each cycle as the END-tagged words come through.
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 2'd3, 32'h3300_0000 + i, (i % 7) == 0, 3'(i), 1'b1, 2'd3,
           1'b1, 2'd3, 1'b0);
    end
    for (int i = 0; i < 80; i++) begin
      step(1'b0, 2'd0, 32'd0, 1'b0, 3'd0, 1'b1, 2'd3, 1'b1, 2'd3, 1'b0);
    end
    chk("sec3_drained", {63'd0, stop3}, 64'd1);

    // Reset with five words in section 2 and a read in flight.
    for (int i = 0; i < 5; i++) wr_only(2'd2, 32'h2200_0000 + i, 1'b0, 3'd1);
    rd_only(2'd2);
    idle(1'b1);
    chk("rst_stop2", {63'd0, stop2}, 64'd1);
    chk("rst_full",  {60'd0, full}, 64'd0);
    chk("rst_data",  {32'd0, lsab_data}, 64'd0);
    wr_only(2'd2, 32'hABCD_0123, 1'b1, 3'd4);
    rd_only(2'd2);
    chk("post_rst_data", {32'd0, lsab_data}, 64'hABCD_0123);
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
